// File: rtl/zeroriscy_multdiv_issue_if.sv
// zeroriscy_multdiv_issue_if: request, multdiv-unit and writeback signals of the mult/div issue stage.
interface zeroriscy_multdiv_issue_if #(parameter int LAT_W = 6);
    logic             req_valid;
    logic             req_ready;
    logic [1:0]       req_operator;
    logic [1:0]       req_signed_mode;
    logic [31:0]      req_op_a;
    logic [31:0]      req_op_b;
    logic [4:0]       req_rd;
    logic             flush;
    logic             mult_en;
    logic             div_en;
    logic [1:0]       operator;
    logic [1:0]       signed_mode;
    logic [31:0]      op_a;
    logic [31:0]      op_b;
    logic             md_ready;
    logic [31:0]      md_result;
    logic             wb_valid;
    logic             wb_ready;
    logic [31:0]      wb_result;
    logic [4:0]       wb_rd;
    logic             busy;
    logic [LAT_W-1:0] last_lat;

    modport slave (
        input  req_valid, req_operator, req_signed_mode, req_op_a, req_op_b, req_rd, flush,
               md_ready, md_result, wb_ready,
        output req_ready, mult_en, div_en, operator, signed_mode, op_a, op_b,
               wb_valid, wb_result, wb_rd, busy, last_lat
    );

    modport master (
        output req_valid, req_operator, req_signed_mode, req_op_a, req_op_b, req_rd, flush,
               md_ready, md_result, wb_ready,
        input  req_ready, mult_en, div_en, operator, signed_mode, op_a, op_b,
               wb_valid, wb_result, wb_rd, busy, last_lat
    );
endinterface

// File: rtl/zeroriscy_multdiv_issue.sv
// zeroriscy_multdiv_issue: issues one mult/div op, holds the unit steady to completion, buffers the result.
module zeroriscy_multdiv_issue #(
    parameter int LAT_W = 6
) (
    input logic                        clk,
    input logic                        rst_n,
    zeroriscy_multdiv_issue_if.slave   io
);
    typedef enum logic [1:0] {IDLE, BUSY, DRAIN, HOLD} state_t;

    state_t             state, state_n;
    logic [1:0]         operator, signed_mode;
    logic [31:0]        op_a, op_b, result;
    logic [4:0]         rd;
    logic               mult_en, div_en;
    logic [LAT_W-1:0]   cnt, cnt_inc, last_lat;
    logic               accept, md_done;

    assign io.req_ready = ~io.flush & (state == IDLE | (state == HOLD & io.wb_ready));
    assign accept       = io.req_valid & io.req_ready;
    // The unit has no kill input, so a flushed op still runs until md_ready
    assign md_done      = (state == BUSY | state == DRAIN) & io.md_ready;
    assign cnt_inc      = &cnt ? cnt : cnt + LAT_W'(1);

    always_comb begin
        state_n = state;
        case (state)
            IDLE:  state_n = accept ? BUSY : IDLE;
            BUSY:  state_n = io.md_ready ? (io.flush ? IDLE : HOLD) : (io.flush ? DRAIN : BUSY);
            DRAIN: state_n = io.md_ready ? IDLE : DRAIN;
            HOLD:  state_n = io.flush ? IDLE : io.wb_ready ? (accept ? BUSY : IDLE) : HOLD;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state       <= IDLE;
            operator    <= '0;
            signed_mode <= '0;
            op_a        <= '0;
            op_b        <= '0;
            rd          <= '0;
            result      <= '0;
            mult_en     <= 1'b0;
            div_en      <= 1'b0;
            cnt         <= '0;
            last_lat    <= '0;
        end else begin
            state <= state_n;
            if (accept) begin
                operator    <= io.req_operator;
                signed_mode <= io.req_signed_mode;
                op_a        <= io.req_op_a;
                op_b        <= io.req_op_b;
                rd          <= io.req_rd;
                cnt         <= '0;
                mult_en     <= ~io.req_operator[1];
                div_en      <= io.req_operator[1];
            end else if (md_done) begin
                mult_en <= 1'b0;
                div_en  <= 1'b0;
            end
            if (state == BUSY)
                cnt <= cnt_inc;
            if (state == BUSY & io.md_ready & ~io.flush) begin
                result   <= io.md_result;
                last_lat <= cnt_inc;
            end
        end
    end

    assign io.mult_en     = mult_en;
    assign io.div_en      = div_en;
    assign io.operator    = operator;
    assign io.signed_mode = signed_mode;
    assign io.op_a        = op_a;
    assign io.op_b        = op_b;
    assign io.wb_valid    = state == HOLD;
    assign io.wb_result   = result;
    assign io.wb_rd       = rd;
    assign io.busy        = state != IDLE;
    assign io.last_lat    = last_lat;
endmodule
